// File: rtl/mips_pkg.sv
// mips_pkg: shared ALU opcodes, execute-control bit positions and forwarding selects
package mips_pkg;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam int EX_REGDST   = 0;
  localparam int EX_ALUSRC   = 1;
  localparam int EX_SHAMT    = 2;
  localparam int EX_ALUOP_LO = 3;
  localparam int EX_ALUOP_HI = 6;
  localparam int EX_LINK     = 7;
  localparam int EX_LINKRA   = 8;
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_WB    = 2'b10;
  localparam logic [4:0] REG_RA = 5'd31;
endpackage

// File: rtl/tl_execute_alu_core.sv
// alu_core: combinational MIPS ALU, shifts act on B by shamt
module alu_core
  import mips_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic [LEN-1:0] i_a,
  input  logic [LEN-1:0] i_b,
  input  logic [4:0]     i_shamt,
  input  logic [3:0]     i_op,
  output logic [LEN-1:0] o_result
);
  // Opcode decode; unused codes 12-15 yield zero
  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_NOR:  o_result = ~(i_a | i_b);
      ALU_SLT:  o_result = {{(LEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
      ALU_SLTU: o_result = {{(LEN-1){1'b0}}, i_a < i_b};
      ALU_SLL:  o_result = i_b << i_shamt;
      ALU_SRL:  o_result = i_b >> i_shamt;
      ALU_SRA:  o_result = $signed(i_b) >>> i_shamt;
      ALU_LUI:  o_result = {i_b[15:0], {(LEN-16){1'b0}}};
      default:  o_result = '0;
    endcase
  end
endmodule

// File: rtl/tl_execute.sv
// tl_execute: EX stage with forwarding, ALU, link/destination select, branch target and EX/MEM register
module tl_execute
  import mips_pkg::*;
#(
  parameter int LEN                  = 32,
  parameter int NB_CTRL_WB           = 2,
  parameter int NB_CTRL_MEM          = 9,
  parameter int NB_CTRL_EX           = 9,
  parameter int NB_ADDRESS_REGISTROS = 5,
  parameter int NB_ALU_OP            = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [LEN-1:0]                  i_pc_plus4,
  input  logic [LEN-1:0]                  i_read_data1,
  input  logic [LEN-1:0]                  i_read_data2,
  input  logic [LEN-1:0]                  i_imm,
  input  logic [4:0]                      i_shamt,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_rt,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_rd,
  input  logic [NB_CTRL_EX-1:0]           i_ctrl_ex,
  input  logic [NB_CTRL_MEM-1:0]          i_ctrl_mem,
  input  logic [NB_CTRL_WB-1:0]           i_ctrl_wb,
  input  logic [1:0]                      i_fwd_a,
  input  logic [1:0]                      i_fwd_b,
  input  logic [LEN-1:0]                  i_wb_data,
  input  logic                            i_hold,
  input  logic                            i_flush,
  output logic [LEN-1:0]                  o_address,
  output logic [LEN-1:0]                  o_write_data,
  output logic                            o_alu_zero,
  output logic [LEN-1:0]                  o_branch_addr,
  output logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg,
  output logic [NB_CTRL_MEM-1:0]          o_ctrl_mem,
  output logic [NB_CTRL_WB-1:0]           o_ctrl_wb
);
  logic [LEN-1:0]                  r_address, r_write_data, r_branch_addr;
  logic                            r_alu_zero;
  logic [NB_ADDRESS_REGISTROS-1:0] r_write_reg;
  logic [NB_CTRL_MEM-1:0]          r_ctrl_mem;
  logic [NB_CTRL_WB-1:0]           r_ctrl_wb;
  logic [LEN-1:0]                  w_a, w_fb, w_b, w_alu, w_result, w_branch;
  logic [4:0]                      w_shamt;
  logic [NB_ALU_OP-1:0]            w_op;
  logic [NB_ADDRESS_REGISTROS-1:0] w_write_reg;
  // Operand forwarding, operand/shift selection, link override and destination choice
  always_comb begin
    w_a = (i_fwd_a == FWD_EXMEM) ? r_address : (i_fwd_a == FWD_WB) ? i_wb_data : i_read_data1;
    w_fb = (i_fwd_b == FWD_EXMEM) ? r_address : (i_fwd_b == FWD_WB) ? i_wb_data : i_read_data2;
    w_b = i_ctrl_ex[EX_ALUSRC] ? i_imm : w_fb;
    w_shamt = i_ctrl_ex[EX_SHAMT] ? i_shamt : w_a[4:0];
    w_op = i_ctrl_ex[EX_ALUOP_HI:EX_ALUOP_LO];
    w_result = i_ctrl_ex[EX_LINK] ? i_pc_plus4 : w_alu;
    w_write_reg = i_ctrl_ex[EX_LINKRA] ? NB_ADDRESS_REGISTROS'(REG_RA) :
                  i_ctrl_ex[EX_REGDST] ? i_rd : i_rt;
    w_branch = i_pc_plus4 + (i_imm << 2);
  end
  alu_core #(.LEN(LEN)) u_alu (
    .i_a     (w_a),
    .i_b     (w_b),
    .i_shamt (w_shamt),
    .i_op    (w_op),
    .o_result(w_alu)
  );
  // EX/MEM register: flush loads data but zeroes control, hold freezes everything
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_address     <= '0;
      r_write_data  <= '0;
      r_alu_zero    <= 1'b0;
      r_branch_addr <= '0;
      r_write_reg   <= '0;
      r_ctrl_mem    <= '0;
      r_ctrl_wb     <= '0;
    end else if (i_flush || !i_hold) begin
      r_address     <= w_result;
      r_write_data  <= w_fb;
      r_alu_zero    <= (w_result == '0);
      r_branch_addr <= w_branch;
      r_write_reg   <= w_write_reg;
      r_ctrl_mem    <= i_flush ? '0 : i_ctrl_mem;
      r_ctrl_wb     <= i_flush ? '0 : i_ctrl_wb;
    end
  end
  assign o_address     = r_address;
  assign o_write_data  = r_write_data;
  assign o_alu_zero    = r_alu_zero;
  assign o_branch_addr = r_branch_addr;
  assign o_write_reg   = r_write_reg;
  assign o_ctrl_mem    = r_ctrl_mem;
  assign o_ctrl_wb     = r_ctrl_wb;
endmodule
